// File: rtl/bgpu_dec_pkg.sv
// rtl/bgpu_dec_pkg.sv - shared types and encoding constants for the pipelined instruction decoder
package bgpu_dec_pkg;

   // Widths of the decoded struct fields. Narrower module-level fields are zero/sign-extended into these.
   localparam int unsigned DEC_OP_W  = 8;
   localparam int unsigned DEC_REG_W = 8;
   localparam int unsigned DEC_IMM_W = 32;

   typedef enum logic [1:0] {
      UNIT_ALU  = 2'd0,
      UNIT_MEM  = 2'd1,
      UNIT_CTRL = 2'd2
   } unit_e;

   // Opcode classes: [0x00,0x0F] ALU, [0x10,0x1F] MEM, 0x20 JMP.
   // STOP is not an opcode: it is the encoded word with every bit set, and it takes priority over the op field.
   localparam logic [DEC_OP_W-1:0] OP_ALU_MAX = 8'h0F;
   localparam logic [DEC_OP_W-1:0] OP_MEM_MIN = 8'h10;
   localparam logic [DEC_OP_W-1:0] OP_MEM_MAX = 8'h1F;
   localparam logic [DEC_OP_W-1:0] OP_JMP     = 8'h20;

   typedef struct packed {
      unit_e                unit;
      logic [DEC_OP_W-1:0]  op;
      logic [DEC_REG_W-1:0] dst;
      logic [DEC_REG_W-1:0] src0;
      logic [DEC_REG_W-1:0] src1;
      logic [DEC_IMM_W-1:0] imm;
      logic                 illegal;
   } dec_inst_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/decoder_pipelined_if.sv
// rtl/decoder_pipelined_if.sv - instruction-cache / dispatcher bus of the pipelined decoder
interface decoder_pipelined_if
   import bgpu_dec_pkg::*;
#(
   parameter int unsigned PcWidth      = 32,
   parameter int unsigned NumWarps     = 8,
   parameter int unsigned WarpWidth    = 32,
   parameter int unsigned EncInstWidth = 32
) ();

   localparam int unsigned WidW = (NumWarps > 1) ? $clog2(NumWarps) : 1;

   // Instruction cache side
   logic                    dec_ready_o;
   logic                    ic_valid_i;
   logic [PcWidth-1:0]      ic_pc_i;
   logic [WarpWidth-1:0]    ic_act_mask_i;
   logic [WidW-1:0]         ic_warp_id_i;
   logic [EncInstWidth-1:0] ic_inst_i;

   // Dispatcher side
   logic                    disp_ready_i;
   logic                    dec_valid_o;
   logic [PcWidth-1:0]      dec_pc_o;
   logic [WarpWidth-1:0]    dec_act_mask_o;
   logic [WidW-1:0]         dec_warp_id_o;
   dec_inst_t               dec_inst_o;

   // Fetcher feedback
   logic                    dec_decoded_o;
   logic                    dec_stop_warp_o;
   logic [WidW-1:0]         dec_decoded_warp_id_o;
   logic [PcWidth-1:0]      dec_decoded_next_pc_o;

   // Decoder side
   modport slave (
      input  ic_valid_i, ic_pc_i, ic_act_mask_i, ic_warp_id_i, ic_inst_i, disp_ready_i,
      output dec_ready_o, dec_valid_o, dec_pc_o, dec_act_mask_o, dec_warp_id_o, dec_inst_o,
             dec_decoded_o, dec_stop_warp_o, dec_decoded_warp_id_o, dec_decoded_next_pc_o
   );

   // Surrounding pipeline side
   modport master (
      output ic_valid_i, ic_pc_i, ic_act_mask_i, ic_warp_id_i, ic_inst_i, disp_ready_i,
      input  dec_ready_o, dec_valid_o, dec_pc_o, dec_act_mask_o, dec_warp_id_o, dec_inst_o,
             dec_decoded_o, dec_stop_warp_o, dec_decoded_warp_id_o, dec_decoded_next_pc_o
   );

endinterface

// File: rtl/inst_field_decoder.sv
// rtl/inst_field_decoder.sv - combinational encoded word to decoded fields, next PC and stop flag
module inst_field_decoder
   import bgpu_dec_pkg::*;
#(
   parameter int unsigned PcWidth      = 32,
   parameter int unsigned EncInstWidth = 32,
   parameter int unsigned OpcodeWidth  = 8,
   parameter int unsigned RegIdxWidth  = 8
) (
   input  logic [EncInstWidth-1:0] inst_i,
   input  logic [PcWidth-1:0]      pc_i,
   output dec_inst_t               dec_o,
   output logic [PcWidth-1:0]      next_pc_o,
   output logic                    stop_o
);

   if (EncInstWidth < OpcodeWidth + 3 * RegIdxWidth) begin : g_bad_enc_width
      $error("EncInstWidth too small for opcode plus three register fields");
   end
   if (OpcodeWidth > DEC_OP_W || RegIdxWidth > DEC_REG_W || RegIdxWidth > DEC_IMM_W) begin : g_bad_field_width
      $error("field widths exceed the decoded struct fields");
   end

   logic [OpcodeWidth-1:0] op_f;
   logic [RegIdxWidth-1:0] dst_f;
   logic [RegIdxWidth-1:0] src0_f;
   logic [RegIdxWidth-1:0] src1_f;
   logic [DEC_OP_W-1:0]    op_x;
   logic                   stop_word;

   assign op_f      = inst_i[OpcodeWidth-1:0];
   assign dst_f     = inst_i[OpcodeWidth                 +: RegIdxWidth];
   assign src0_f    = inst_i[OpcodeWidth + RegIdxWidth   +: RegIdxWidth];
   assign src1_f    = inst_i[OpcodeWidth + 2*RegIdxWidth +: RegIdxWidth];
   assign op_x      = DEC_OP_W'(op_f);
   assign stop_word = &inst_i;

   // Classify the word and compute the successor PC; anything unrecognised is flagged illegal and stops the warp.
   always_comb begin
      dec_o         = '0;
      dec_o.unit    = UNIT_ALU;
      dec_o.op      = op_x;
      dec_o.dst     = DEC_REG_W'(dst_f);
      dec_o.src0    = DEC_REG_W'(src0_f);
      dec_o.src1    = DEC_REG_W'(src1_f);
      dec_o.imm     = DEC_IMM_W'($signed(src1_f));
      dec_o.illegal = 1'b0;
      next_pc_o     = pc_i + PcWidth'(1);
      stop_o        = 1'b0;
      if (stop_word) begin
         dec_o.unit = UNIT_CTRL;
         stop_o     = 1'b1;
      end else if (op_x <= OP_ALU_MAX) begin
         dec_o.unit = UNIT_ALU;
      end else if (op_x >= OP_MEM_MIN && op_x <= OP_MEM_MAX) begin
         dec_o.unit = UNIT_MEM;
      end else if (op_x == OP_JMP) begin
         dec_o.unit = UNIT_CTRL;
         next_pc_o  = pc_i + PcWidth'($signed(src1_f));
      end else begin
         dec_o.illegal = 1'b1;
         stop_o        = 1'b1;
      end
   end

endmodule

// File: rtl/decoder_pipelined.sv
// rtl/decoder_pipelined.sv - registered decoder with skid buffer; optional counters under DECODER_PERF_CNT_EN
module decoder_pipelined
   import bgpu_dec_pkg::*;
#(
   parameter int unsigned PcWidth      = 32,
   parameter int unsigned NumWarps     = 8,
   parameter int unsigned WarpWidth    = 32,
   parameter int unsigned EncInstWidth = 32,
   parameter int unsigned OpcodeWidth  = 8,
   parameter int unsigned RegIdxWidth  = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   decoder_pipelined_if.slave  bus
`ifdef DECODER_PERF_CNT_EN
   ,
   output logic [31:0]         perf_decoded_o,
   output logic [31:0]         perf_stall_o,
   output logic [31:0]         perf_illegal_o
`endif
);

   localparam int unsigned WidW = (NumWarps > 1) ? $clog2(NumWarps) : 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   // One buffered instruction: the decode result travels with its metadata, next PC and stop flag.
   typedef struct packed {
      logic [PcWidth-1:0]   pc;
      logic [WarpWidth-1:0] mask;
      logic [WidW-1:0]      wid;
      dec_inst_t            inst;
      logic [PcWidth-1:0]   next_pc;
      logic                 stop;
   } entry_t;

   state_e state_q, state_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   entry_t new_entry;

   dec_inst_t          fd_inst;
   logic [PcWidth-1:0] fd_next_pc;
   logic               fd_stop;

   logic ready;
   logic valid;
   logic in_hs;
   logic out_hs;

   inst_field_decoder #(
      .PcWidth      (PcWidth),
      .EncInstWidth (EncInstWidth),
      .OpcodeWidth  (OpcodeWidth),
      .RegIdxWidth  (RegIdxWidth)
   ) u_field_dec (
      .inst_i    (bus.ic_inst_i),
      .pc_i      (bus.ic_pc_i),
      .dec_o     (fd_inst),
      .next_pc_o (fd_next_pc),
      .stop_o    (fd_stop)
   );

   assign new_entry = '{
      pc:      bus.ic_pc_i,
      mask:    bus.ic_act_mask_i,
      wid:     bus.ic_warp_id_i,
      inst:    fd_inst,
      next_pc: fd_next_pc,
      stop:    fd_stop
   };

   // Ready and valid are decodes of the state register only, so ready never sees disp_ready_i combinationally.
   assign ready  = (state_q != ST_SKID);
   assign valid  = (state_q != ST_EMPTY);
   assign in_hs  = bus.ic_valid_i & ready;
   assign out_hs = valid & bus.disp_ready_i;

   // Next-state logic: OUT always holds the oldest entry, SKID catches the one accepted while OUT was stalled.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_hs) begin
               state_d = ST_FULL;
               out_d   = new_entry;
            end
         end
         ST_FULL: begin
            if (in_hs && out_hs) begin
               out_d = new_entry;
            end else if (out_hs) begin
               state_d = ST_EMPTY;
            end else if (in_hs) begin
               state_d = ST_SKID;
               skid_d  = new_entry;
            end
         end
         ST_SKID: begin
            if (out_hs) begin
               state_d = ST_FULL;
               out_d   = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State and storage registers; reset discards anything in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign bus.dec_ready_o           = ready;
   assign bus.dec_valid_o           = valid;
   assign bus.dec_pc_o              = out_q.pc;
   assign bus.dec_act_mask_o        = out_q.mask;
   assign bus.dec_warp_id_o         = out_q.wid;
   assign bus.dec_inst_o            = out_q.inst;
   assign bus.dec_decoded_o         = out_hs;
   assign bus.dec_stop_warp_o       = out_q.stop;
   assign bus.dec_decoded_warp_id_o = out_q.wid;
   assign bus.dec_decoded_next_pc_o = out_q.next_pc;

`ifdef DECODER_PERF_CNT_EN
   logic [31:0] perf_decoded_q;
   logic [31:0] perf_stall_q;
   logic [31:0] perf_illegal_q;

   // Saturating event counters: handovers, backpressure cycles, illegal handovers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_decoded_q <= '0;
         perf_stall_q   <= '0;
         perf_illegal_q <= '0;
      end else begin
         if (out_hs) begin
            perf_decoded_q <= sat_inc32(perf_decoded_q);
         end
         if (valid && !bus.disp_ready_i) begin
            perf_stall_q <= sat_inc32(perf_stall_q);
         end
         if (out_hs && out_q.inst.illegal) begin
            perf_illegal_q <= sat_inc32(perf_illegal_q);
         end
      end
   end

   assign perf_decoded_o = perf_decoded_q;
   assign perf_stall_o   = perf_stall_q;
   assign perf_illegal_o = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decoder_pipelined.sv
// tb/tb_decoder_pipelined.sv - self-checking bench for decoder_pipelined
module tb_decoder_pipelined;
   import bgpu_dec_pkg::*;

   logic clk_i;
   logic rst_ni;

   decoder_pipelined_if bus ();

`ifdef DECODER_PERF_CNT_EN
   logic [31:0] perf_decoded;
   logic [31:0] perf_stall;
   logic [31:0] perf_illegal;
`endif

   decoder_pipelined dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
`ifdef DECODER_PERF_CNT_EN
      ,
      .perf_decoded_o (perf_decoded),
      .perf_stall_o   (perf_stall),
      .perf_illegal_o (perf_illegal)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      dec_inst_t   exp;
      logic [31:0] next_pc;
      logic        stop;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  op;
      logic [7:0]  dst;
   } sb_t;

   vec_t vecs[12];
   sb_t  sbq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic rdy);
      bus.ic_valid_i    = v;
      bus.ic_inst_i     = inst;
      bus.ic_pc_i       = pc;
      bus.ic_act_mask_i = pc ^ 32'hA5A5_A5A5;
      bus.ic_warp_id_i  = pc[2:0];
      bus.disp_ready_i  = rdy;
      #1;
   endtask

   function automatic dec_inst_t mk(input unit_e u, input logic [7:0] op, input logic [7:0] dst,
                                    input logic [7:0] s0, input logic [7:0] s1,
                                    input logic [31:0] imm, input logic ill);
      dec_inst_t d;
      d.unit    = u;
      d.op      = op;
      d.dst     = dst;
      d.src0    = s0;
      d.src1    = s1;
      d.imm     = imm;
      d.illegal = ill;
      return d;
   endfunction

   logic        r_v;
   logic        r_rdy;
   logic [7:0]  r_op;
   logic [7:0]  r_dst;
   logic [31:0] pc_gen;
   logic        prev_stall;
   logic [31:0] prev_pc;
   dec_inst_t   prev_inst;
   sb_t         e;

   initial begin
      // Hand-decoded vectors: word = {src1, src0, dst, op}
      vecs[0]  = '{32'h0504_0301, 32'h0000_0010, mk(UNIT_ALU,  8'h01, 8'h03, 8'h04, 8'h05, 32'h0000_0005, 1'b0), 32'h0000_0011, 1'b0};
      vecs[1]  = '{32'hFE00_0020, 32'h0000_0010, mk(UNIT_CTRL, 8'h20, 8'h00, 8'h00, 8'hFE, 32'hFFFF_FFFE, 1'b0), 32'h0000_000E, 1'b0};
      vecs[2]  = '{32'hFF00_0020, 32'h0000_0000, mk(UNIT_CTRL, 8'h20, 8'h00, 8'h00, 8'hFF, 32'hFFFF_FFFF, 1'b0), 32'hFFFF_FFFF, 1'b0};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0020, mk(UNIT_CTRL, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b0), 32'h0000_0021, 1'b1};
      vecs[4]  = '{32'h0000_007F, 32'h0000_0030, mk(UNIT_ALU,  8'h7F, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b1), 32'h0000_0031, 1'b1};
      vecs[5]  = '{32'h7F02_0115, 32'h0000_0040, mk(UNIT_MEM,  8'h15, 8'h01, 8'h02, 8'h7F, 32'h0000_007F, 1'b0), 32'h0000_0041, 1'b0};
      vecs[6]  = '{32'h0000_000F, 32'hFFFF_FFFF, mk(UNIT_ALU,  8'h0F, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0), 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h0000_0010, 32'h0000_0050, mk(UNIT_MEM,  8'h10, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0), 32'h0000_0051, 1'b0};
      vecs[8]  = '{32'h8000_001F, 32'h0000_0060, mk(UNIT_MEM,  8'h1F, 8'h00, 8'h00, 8'h80, 32'hFFFF_FF80, 1'b0), 32'h0000_0061, 1'b0};
      vecs[9]  = '{32'h0000_0021, 32'h0000_0070, mk(UNIT_ALU,  8'h21, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b1), 32'h0000_0071, 1'b1};
      vecs[10] = '{32'h0000_00FF, 32'h0000_0080, mk(UNIT_ALU,  8'hFF, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b1), 32'h0000_0081, 1'b1};
      vecs[11] = '{32'h0102_0320, 32'h0000_0100, mk(UNIT_CTRL, 8'h20, 8'h03, 8'h02, 8'h01, 32'h0000_0001, 1'b0), 32'h0000_0101, 1'b0};

      // Reset state, with junk offered on the input while reset is held
      rst_ni = 1'b0;
      drive(1'b1, 32'h1234_5678, 32'h0000_0ABC, 1'b1);
      tick();
      tick();
      check("rst_valid",   bus.dec_valid_o,   1'b0);
      check("rst_ready",   bus.dec_ready_o,   1'b1);
      check("rst_decoded", bus.dec_decoded_o, 1'b0);
      check("rst_pc",      bus.dec_pc_o,      32'h0);
      check("rst_inst",    bus.dec_inst_o,    67'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      rst_ni = 1'b1;
      tick();

      // Table vectors, streamed back to back with the dispatcher always ready
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vecs[i].inst, vecs[i].pc, 1'b1);
         tick();
         drive(1'b0, 32'h0, 32'h0, 1'b1);
         check($sformatf("v%0d_valid", i),   bus.dec_valid_o,           1'b1);
         check($sformatf("v%0d_decoded", i), bus.dec_decoded_o,         1'b1);
         check($sformatf("v%0d_inst", i),    bus.dec_inst_o,            vecs[i].exp);
         check($sformatf("v%0d_next_pc", i), bus.dec_decoded_next_pc_o, vecs[i].next_pc);
         check($sformatf("v%0d_stop", i),    bus.dec_stop_warp_o,       vecs[i].stop);
         check($sformatf("v%0d_pc", i),      bus.dec_pc_o,              vecs[i].pc);
         check($sformatf("v%0d_mask", i),    bus.dec_act_mask_o,        vecs[i].pc ^ 32'hA5A5_A5A5);
         check($sformatf("v%0d_wid", i),     bus.dec_decoded_warp_id_o, {29'h0, vecs[i].pc[2:0]});
      end
      tick();
      check("drain_valid", bus.dec_valid_o, 1'b0);

      // Three back-to-back words, dispatcher stalled for the first two cycles
      drive(1'b1, 32'h0000_0001, 32'h0000_0200, 1'b0);
      check("bp_c0_ready", bus.dec_ready_o, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0002, 32'h0000_0204, 1'b0);
      check("bp_c1_ready", bus.dec_ready_o, 1'b1);
      check("bp_c1_pc",    bus.dec_pc_o,    32'h0000_0200);
      tick();
      drive(1'b1, 32'h0000_0003, 32'h0000_0208, 1'b1);
      check("bp_c2_ready",   bus.dec_ready_o,   1'b0);
      check("bp_c2_pc",      bus.dec_pc_o,      32'h0000_0200);
      check("bp_c2_decoded", bus.dec_decoded_o, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0003, 32'h0000_0208, 1'b1);
      check("bp_c3_ready",   bus.dec_ready_o,   1'b1);
      check("bp_c3_pc",      bus.dec_pc_o,      32'h0000_0204);
      check("bp_c3_decoded", bus.dec_decoded_o, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      check("bp_c4_pc",      bus.dec_pc_o,      32'h0000_0208);
      check("bp_c4_op",      bus.dec_inst_o.op, 8'h03);
      check("bp_c4_decoded", bus.dec_decoded_o, 1'b1);
      tick();
      check("bp_c5_valid", bus.dec_valid_o, 1'b0);

      // Reset while both OUT and SKID are occupied
      drive(1'b1, 32'h0000_0004, 32'h0000_0300, 1'b0);
      tick();
      drive(1'b1, 32'h0000_0005, 32'h0000_0304, 1'b0);
      tick();
      check("skid_ready_low", bus.dec_ready_o, 1'b0);
      rst_ni = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      rst_ni = 1'b1;
      check("skid_rst_valid",   bus.dec_valid_o,   1'b0);
      check("skid_rst_ready",   bus.dec_ready_o,   1'b1);
      check("skid_rst_decoded", bus.dec_decoded_o, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("skid_post%0d_valid", k), bus.dec_valid_o, 1'b0);
      end

      // Random valid/ready stress against an in-order scoreboard, then drain
      pc_gen     = 32'h0000_1000;
      prev_stall = 1'b0;
      prev_pc    = '0;
      prev_inst  = '0;
      for (int c = 0; c < 420; c++) begin
         tick();
         r_op  = 8'($urandom_range(0, 15));
         r_dst = 8'($urandom_range(0, 255));
         if (c < 400) begin
            r_v   = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 2) != 0);
         end else begin
            r_v   = 1'b0;
            r_rdy = 1'b1;
         end
         drive(r_v, {16'h0, r_dst, r_op}, pc_gen, r_rdy);
         if (prev_stall) begin
            check("stress_stable_pc",   bus.dec_pc_o,   prev_pc);
            check("stress_stable_inst", bus.dec_inst_o, prev_inst);
         end
         if (bus.dec_decoded_o) begin
            if (sbq.size() == 0) begin
               check("stress_spurious", 1'b1, 1'b0);
            end else begin
               e = sbq.pop_front();
               check("stress_pc",      bus.dec_pc_o,              e.pc);
               check("stress_op",      bus.dec_inst_o.op,         e.op);
               check("stress_dst",     bus.dec_inst_o.dst,        e.dst);
               check("stress_next_pc", bus.dec_decoded_next_pc_o, e.pc + 32'd1);
            end
         end
         if (r_v && bus.dec_ready_o) begin
            sbq.push_back('{pc_gen, r_op, r_dst});
            pc_gen = pc_gen + 32'd1;
         end
         prev_stall = bus.dec_valid_o & ~bus.disp_ready_i;
         prev_pc    = bus.dec_pc_o;
         prev_inst  = bus.dec_inst_o;
      end
      check("stress_sb_empty", 32'(sbq.size()), 32'd0);
      check("stress_end_valid", bus.dec_valid_o, 1'b0);

`ifdef DECODER_PERF_CNT_EN
      // 5 handovers (one illegal) and 3 stall cycles from a fresh reset
      rst_ni = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      rst_ni = 1'b1;
      check("perf_rst_decoded", perf_decoded, 32'd0);
      drive(1'b1, 32'h0000_0001, 32'h0000_0400, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h0000_0002, 32'h0000_0404, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0003, 32'h0000_0408, 1'b1);
      tick();
      drive(1'b1, 32'h0000_007F, 32'h0000_040C, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0004, 32'h0000_0410, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      check("perf_decoded", perf_decoded, 32'd5);
      check("perf_stall",   perf_stall,   32'd3);
      check("perf_illegal", perf_illegal, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
